mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory/write-back pipeline register of a 5-stage RISC pipeline. It captures
// the instruction leaving the memory stage, formats load data (byte/halfword
// extraction with sign or zero extension), drives the register-file write port
// and forwards the pending write to the decode-stage read ports. It also counts
// retired instructions.
//
// Parameters
//   DATA_W      register/data width (load formatting assumes DATA_W >= 32)
//   ADDR_W      register address width
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   inValid, inWe, inWAddr        slot valid, write enable, destination reg
//   inAluData                     non-load result
//   inIsLoad, inLoadType          load select and load format code
//   inMemData, inByteOff          raw memory word and address bits [1:0]
//   stall, flush                  hold stage / invalidate captured slot
//   we, wAddr, wData              registered register-file write port
//   regaAddr/regbAddr, regaRaw/regbRaw   register-file reads from decode
//   regaData, regbData            read data after write-back bypass
//   retCount                      retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic              inWe,
    input  logic [ADDR_W-1:0] inWAddr,
    input  logic [DATA_W-1:0] inAluData,
    input  logic              inIsLoad,
    input  logic [2:0]        inLoadType,
    input  logic [DATA_W-1:0] inMemData,
    input  logic [1:0]        inByteOff,
    input  logic              stall,
    input  logic              flush,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    input  logic [ADDR_W-1:0] regaAddr,
    input  logic [ADDR_W-1:0] regbAddr,
    input  logic [DATA_W-1:0] regaRaw,
    input  logic [DATA_W-1:0] regbRaw,
    output logic [DATA_W-1:0] regaData,
    output logic [DATA_W-1:0] regbData,
    output logic [31:0]       retCount
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Little-endian lane extraction. Halfwords are selected by the upper
    // offset bit only, so a misaligned LH/LHU reads the aligned halfword.
    // LW and the reserved codes pass the memory word through untouched.
    function automatic logic [DATA_W-1:0] format_load(
        input logic [2:0]        load_type,
        input logic [DATA_W-1:0] mem_word,
        input logic [1:0]        byte_off
    );
        logic [7:0]        byte_s;
        logic [15:0]       half_s;
        logic [DATA_W-1:0] result_s;
        byte_s = mem_word[{byte_off, 3'b000} +: 8];
        half_s = mem_word[{byte_off[1], 4'b0000} +: 16];
        case (load_type)
            LT_LW:   result_s = mem_word;
            LT_LB:   result_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
            LT_LBU:  result_s = {{(DATA_W-8){1'b0}}, byte_s};
            LT_LH:   result_s = {{(DATA_W-16){half_s[15]}}, half_s};
            LT_LHU:  result_s = {{(DATA_W-16){1'b0}}, half_s};
            default: result_s = mem_word;
        endcase
        return result_s;
    endfunction

    // The valid bit is folded into we_q: a slot that is invalid, does not
    // write, or targets r0 simply produces no write. Because r0 never raises
    // we_q, the bypass below can never forward to address 0.
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [31:0]       ret_count_q, ret_count_d;

    // Next-state selection: flush beats stall, stall holds, otherwise capture.
    always_comb begin
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        ret_count_d = ret_count_q;
        if (flush) begin
            we_d = 1'b0;
        end else if (stall) begin
            we_d = we_q;
        end else begin
            we_d        = inValid & inWe & (inWAddr != {ADDR_W{1'b0}});
            waddr_d     = inWAddr;
            wdata_d     = inIsLoad ? format_load(inLoadType, inMemData, inByteOff)
                                   : inAluData;
            ret_count_d = ret_count_q + {31'b0, inValid};
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q        <= 1'b0;
            waddr_q     <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            ret_count_q <= 32'd0;
        end else begin
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ret_count_q <= ret_count_d;
        end
    end

    assign we       = we_q;
    assign wAddr    = waddr_q;
    assign wData    = wdata_q;
    assign retCount = ret_count_q;

    // Write-back bypass so decode sees the value being written this cycle.
    always_comb begin
        regaData = regaRaw;
        regbData = regbRaw;
        if (we_q && (waddr_q == regaAddr)) begin
            regaData = wdata_q;
        end else begin
            regaData = regaRaw;
        end
        if (we_q && (waddr_q == regbAddr)) begin
            regbData = wdata_q;
        end else begin
            regbData = regbRaw;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inWe;
    logic [4:0]  inWAddr;
    logic [31:0] inAluData;
    logic        inIsLoad;
    logic [2:0]  inLoadType;
    logic [31:0] inMemData;
    logic [1:0]  inByteOff;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [4:0]  regaAddr;
    logic [4:0]  regbAddr;
    logic [31:0] regaRaw;
    logic [31:0] regbRaw;
    logic [31:0] regaData;
    logic [31:0] regbData;
    logic [31:0] retCount;

    int checks_cnt;
    int errors_cnt;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .inWe       (inWe),
        .inWAddr    (inWAddr),
        .inAluData  (inAluData),
        .inIsLoad   (inIsLoad),
        .inLoadType (inLoadType),
        .inMemData  (inMemData),
        .inByteOff  (inByteOff),
        .stall      (stall),
        .flush      (flush),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .regaAddr   (regaAddr),
        .regbAddr   (regbAddr),
        .regaRaw    (regaRaw),
        .regbRaw    (regbRaw),
        .regaData   (regaData),
        .regbData   (regbData),
        .retCount   (retCount)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic w, input logic [4:0] a,
                          input logic [31:0] alu, input logic ld, input logic [2:0] lt,
                          input logic [31:0] mem, input logic [1:0] off);
        inValid    = v;
        inWe       = w;
        inWAddr    = a;
        inAluData  = alu;
        inIsLoad   = ld;
        inLoadType = lt;
        inMemData  = mem;
        inByteOff  = off;
    endtask

    // advance one rising edge and sample 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads[7];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        regaAddr = 5'd0; regbAddr = 5'd0;
        regaRaw = 32'd0; regbRaw = 32'd0;
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0, 2'd0);

        loads[0] = '{"LB_off1",   3'b001, 2'd1, 32'h0000_007F};
        loads[1] = '{"LB_off2",   3'b001, 2'd2, 32'hFFFF_FFFF};
        loads[2] = '{"LBU_off3",  3'b010, 2'd3, 32'h0000_0080};
        loads[3] = '{"LH_off2",   3'b011, 2'd2, 32'hFFFF_80FF};
        loads[4] = '{"LHU_off0",  3'b100, 2'd0, 32'h0000_7F01};
        loads[5] = '{"LH_off1",   3'b011, 2'd1, 32'h0000_7F01};
        loads[6] = '{"RSV_off2",  3'b110, 2'd2, 32'h80FF_7F01};

        // reset state
        step();
        check_eq("rst_we",    {31'd0, we}, 32'd0);
        check_eq("rst_waddr", {27'd0, wAddr}, 32'd0);
        check_eq("rst_wdata", wData, 32'd0);
        check_eq("rst_ret",   retCount, 32'd0);
        rst = 1'b1;

        // ALU capture
        set_in(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 32'hFFFF_FFFF, 2'd0);
        step();
        check_eq("alu_we",    {31'd0, we}, 32'd1);
        check_eq("alu_waddr", {27'd0, wAddr}, 32'd5);
        check_eq("alu_wdata", wData, 32'h1234_5678);
        check_eq("alu_ret",   retCount, 32'd1);

        // load formatting
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, loads[i].lt, 32'h80FF_7F01, loads[i].off);
            step();
            check_eq(loads[i].tag, wData, loads[i].exp);
        end
        check_eq("load_ret", retCount, 32'd8);

        // write to r0: no write, no bypass, still retires
        set_in(1'b1, 1'b1, 5'd0, 32'h0000_ABCD, 1'b0, 3'd0, 32'd0, 2'd0);
        regaAddr = 5'd0; regaRaw = 32'd0;
        step();
        check_eq("r0_we",   {31'd0, we}, 32'd0);
        check_eq("r0_rega", regaData, 32'd0);
        regaRaw = 32'h0000_0055;
        #1;
        check_eq("r0_nobyp", regaData, 32'h0000_0055);
        check_eq("r0_ret",  retCount, 32'd9);

        // bypass
        set_in(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'd0, 2'd0);
        step();
        regaAddr = 5'd7; regaRaw = 32'h0000_1111;
        regbAddr = 5'd8; regbRaw = 32'h0000_2222;
        #1;
        check_eq("byp_a", regaData, 32'hDEAD_BEEF);
        check_eq("byp_b", regbData, 32'h0000_2222);
        regbAddr = 5'd7;
        #1;
        check_eq("byp_b7", regbData, 32'hDEAD_BEEF);
        check_eq("byp_ret", retCount, 32'd10);

        // invalid slot: no write, no retire
        set_in(1'b0, 1'b1, 5'd7, 32'h0000_0777, 1'b0, 3'd0, 32'd0, 2'd0);
        step();
        check_eq("inv_we",  {31'd0, we}, 32'd0);
        check_eq("inv_ret", retCount, 32'd10);

        // recapture, then stall 3 cycles, then flush with stall held
        set_in(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'd0, 2'd0);
        step();
        check_eq("pre_stall_ret", retCount, 32'd11);
        stall = 1'b1;
        set_in(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 3'd0, 32'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_we",    {31'd0, we}, 32'd1);
            check_eq("stall_waddr", {27'd0, wAddr}, 32'd7);
            check_eq("stall_wdata", wData, 32'hDEAD_BEEF);
            check_eq("stall_ret",   retCount, 32'd11);
        end
        flush = 1'b1;
        step();
        check_eq("flush_we",  {31'd0, we}, 32'd0);
        check_eq("flush_ret", retCount, 32'd11);
        regaAddr = 5'd7; regaRaw = 32'h0000_1111;
        #1;
        check_eq("flush_nobyp", regaData, 32'h0000_1111);
        flush = 1'b0;

        // capture a write while stalled-off, then hold it under stall
        stall = 1'b0;
        set_in(1'b1, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 3'd0, 32'd0, 2'd0);
        step();
        check_eq("cap4_we",  {31'd0, we}, 32'd1);
        check_eq("cap4_ret", retCount, 32'd12);
        stall = 1'b1;

        // async reset between edges with we=1, retCount=all-ones
        force dut.ret_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ret_count_q;
        #1;
        check_eq("pre_rst_ret", retCount, 32'hFFFF_FFFF);
        check_eq("pre_rst_we",  {31'd0, we}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("arst_we",    {31'd0, we}, 32'd0);
        check_eq("arst_wdata", wData, 32'd0);
        check_eq("arst_waddr", {27'd0, wAddr}, 32'd0);
        check_eq("arst_ret",   retCount, 32'd0);
        // reset wins over stall/flush and blocks capture across an edge
        stall = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check_eq("hold_rst_we",  {31'd0, we}, 32'd0);
        check_eq("hold_rst_ret", retCount, 32'd0);
        rst = 1'b1;
        step();
        check_eq("post_rst_we",  {31'd0, we}, 32'd1);
        check_eq("post_rst_ret", retCount, 32'd1);

        // counter wrap
        stall = 1'b1;
        force dut.ret_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ret_count_q;
        #1;
        stall = 1'b0;
        step();
        check_eq("wrap_ret", retCount, 32'd0);
        check_eq("wrap_we",  {31'd0, we}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
